// File: rtl/display_7seg_scan.sv
// Time-multiplexed common-anode 7-segment driver: latches a hex word and scans one digit per CLK_DIV cycles.
// Optional leading-zero blanking is enabled by defining DISPLAY_7SEG_SCAN_LZB_EN.
module display_7seg_scan #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      load,
    input  logic                      en,
    output logic [6:0]                seg,
    output logic [DATA_WIDTH/4-1:0]   an,
    output logic                      frame_tick
);
    localparam int NUM_DIGITS = DATA_WIDTH / 4;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0]         IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE    = NUM_DIGITS'(1);
    localparam logic [6:0]            SEG_BLANK = 7'b1111111;

    logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  frame_tick_q, frame_tick_d;
    logic                  presc_wrap;
    logic [3:0]            nibble;
    logic [6:0]            seg_digit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'b0000001;
            4'h1: hex7 = 7'b1001111;
            4'h2: hex7 = 7'b0010010;
            4'h3: hex7 = 7'b0000110;
            4'h4: hex7 = 7'b1001100;
            4'h5: hex7 = 7'b0100100;
            4'h6: hex7 = 7'b0100000;
            4'h7: hex7 = 7'b0001111;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0000100;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b1100000;
            4'hC: hex7 = 7'b0110001;
            4'hD: hex7 = 7'b1000010;
            4'hE: hex7 = 7'b0110000;
            default: hex7 = 7'b0111000;
        endcase
    endfunction

`ifdef DISPLAY_7SEG_SCAN_LZB_EN
    logic [IW-1:0] top_nz;
    always_comb begin
        // Highest nonzero nibble; stays 0 for an all-zero word so digit 0 always shows.
        top_nz = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (shadow_q[k*4 +: 4] != 4'h0) top_nz = IW'(k);
        end
    end
`endif

    always_comb begin
        nibble = 4'h0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) nibble = shadow_q[k*4 +: 4];
        end
`ifdef DISPLAY_7SEG_SCAN_LZB_EN
        seg_digit = (idx_q > top_nz) ? SEG_BLANK : hex7(nibble);
`else
        seg_digit = hex7(nibble);
`endif
    end

    always_comb begin
        shadow_d     = load ? data_in : shadow_q;
        presc_wrap   = (presc_q == PRESC_MAX);
        presc_d      = presc_q;
        idx_d        = idx_q;
        an_d         = '1;
        seg_d        = SEG_BLANK;
        frame_tick_d = 1'b0;
        if (en) begin
            if (presc_wrap) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
            an_d         = ~(AN_ONE << idx_q);
            seg_d        = seg_digit;
            frame_tick_d = presc_wrap && (idx_q == IDX_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '0;
            presc_q      <= '0;
            idx_q        <= '0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            shadow_q     <= shadow_d;
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_display_7seg_scan.sv
// Bench for display_7seg_scan: a CLK_DIV=4 instance checked by a scoreboard, a CLK_DIV=1 instance checked directly.
module tb_display_7seg_scan;
    localparam int DW = 16;
    localparam int ND = DW / 4;
    localparam int CD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a = 1'b1, load_a = 1'b0, en_a = 1'b0;
    logic [DW-1:0] data_a = '0;
    logic [6:0]    seg_a;
    logic [ND-1:0] an_a;
    logic          ft_a;

    logic          rst_b = 1'b1, load_b = 1'b0, en_b = 1'b0;
    logic [DW-1:0] data_b = '0;
    logic [6:0]    seg_b;
    logic [ND-1:0] an_b;
    logic          ft_b;

    display_7seg_scan #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut_a (
        .clk(clk), .rst(rst_a), .data_in(data_a), .load(load_a), .en(en_a),
        .seg(seg_a), .an(an_a), .frame_tick(ft_a));

    display_7seg_scan #(.DATA_WIDTH(DW), .CLK_DIV(1)) dut_b (
        .clk(clk), .rst(rst_b), .data_in(data_b), .load(load_b), .en(en_b),
        .seg(seg_b), .an(an_b), .frame_tick(ft_b));

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] ref_hex(input logic [3:0] n);
        case (n)
            4'h0: ref_hex = 7'b0000001;  4'h1: ref_hex = 7'b1001111;
            4'h2: ref_hex = 7'b0010010;  4'h3: ref_hex = 7'b0000110;
            4'h4: ref_hex = 7'b1001100;  4'h5: ref_hex = 7'b0100100;
            4'h6: ref_hex = 7'b0100000;  4'h7: ref_hex = 7'b0001111;
            4'h8: ref_hex = 7'b0000000;  4'h9: ref_hex = 7'b0000100;
            4'hA: ref_hex = 7'b0001000;  4'hB: ref_hex = 7'b1100000;
            4'hC: ref_hex = 7'b0110001;  4'hD: ref_hex = 7'b1000010;
            4'hE: ref_hex = 7'b0110000;  default: ref_hex = 7'b0111000;
        endcase
    endfunction

    function automatic logic [6:0] ref_digit(input logic [DW-1:0] word, input int d);
        int top;
        top = 0;
        for (int k = 0; k < ND; k++) if (word[k*4 +: 4] != 4'h0) top = k;
`ifdef DISPLAY_7SEG_SCAN_LZB_EN
        if (d > top) return 7'b1111111;
`endif
        return ref_hex(word[d*4 +: 4]);
    endfunction

    // Reference model of dut_a; expected {an, seg, frame_tick} queued each edge.
    logic [DW-1:0]   m_shadow = '0;
    int              m_presc = 0;
    int              m_idx = 0;
    logic [ND+7:0]   exp_q[$];

    always @(posedge clk) begin
        logic [ND-1:0] e_an;
        logic [6:0]    e_seg;
        logic          e_ft;
        if (rst_a) begin
            e_an = '1; e_seg = 7'h7F; e_ft = 1'b0;
            m_shadow = '0; m_presc = 0; m_idx = 0;
        end else begin
            if (en_a) begin
                e_an  = ~(ND'(1) << m_idx);
                e_seg = ref_digit(m_shadow, m_idx);
                e_ft  = (m_presc == CD - 1) && (m_idx == ND - 1);
                if (m_presc == CD - 1) begin
                    m_presc = 0;
                    m_idx = (m_idx + 1) % ND;
                end else begin
                    m_presc++;
                end
            end else begin
                e_an = '1; e_seg = 7'h7F; e_ft = 1'b0;
            end
            if (load_a) m_shadow = data_a;
        end
        exp_q.push_back({e_an, e_seg, e_ft});
    end

    always @(negedge clk) begin
        logic [ND+7:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("a_an", 32'(an_a), 32'(e[ND+7:8]));
            check_val("a_seg", 32'(seg_a), 32'(e[7:1]));
            check_val("a_ft", 32'(ft_a), 32'(e[0]));
        end
    end

    task automatic step_a(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_model(input int idx, input int presc, input string tag);
        int budget;
        budget = 0;
        while (!(m_idx == idx && m_presc == presc) && budget < 100) begin
            step_a(1);
            budget++;
        end
        check_val(tag, 32'(budget < 100), 32'd1);
    endtask

    initial begin
        // Reset held with load asserted: shadow must stay zero.
        rst_a = 1'b1; load_a = 1'b1; data_a = 16'hFFFF; en_a = 1'b1;
        step_a(3);
        check_val("rst_an", 32'(an_a), 32'hF);
        check_val("rst_seg", 32'(seg_a), 32'h7F);
        check_val("rst_ft", 32'(ft_a), 32'h0);
        rst_a = 1'b0; load_a = 1'b0;
        step_a(1);
        check_val("post_rst_seg0", 32'(seg_a), 32'(7'b0000001));
        check_val("post_rst_an0", 32'(an_a), 32'(4'b1110));
        step_a(6);

        // Scan 12AF across several frames.
        load_a = 1'b1; data_a = 16'h12AF;
        step_a(1);
        load_a = 1'b0;
        step_a(40);

        // Freeze during digit 2 after one of its cycles.
        wait_model(2, 1, "wait_d2");
        en_a = 1'b0;
        step_a(10);
        check_val("frz_an", 32'(an_a), 32'hF);
        check_val("frz_seg", 32'(seg_a), 32'h7F);
        en_a = 1'b1;
        step_a(20);

        // Load while digit 1 is lit.
        wait_model(1, 1, "wait_d1");
        load_a = 1'b1; data_a = 16'h3333;
        step_a(1);
        load_a = 1'b0;
        step_a(1);
        check_val("ld_mid_seg", 32'(seg_a), 32'(7'b0000110));
        step_a(20);

        // Leading-zero cases.
        load_a = 1'b1; data_a = 16'h0005;
        step_a(1);
        load_a = 1'b0;
        step_a(20);
        load_a = 1'b1; data_a = 16'h0000;
        step_a(1);
        load_a = 1'b0;
        step_a(20);

        // Random traffic including load on a digit advance and mid-scan resets.
        for (int i = 0; i < 200; i++) begin
            rst_a  = ($urandom_range(0, 39) == 0);
            en_a   = ($urandom_range(0, 5) != 0);
            load_a = ($urandom_range(0, 7) == 0);
            data_a = DW'($urandom_range(0, 65535));
            if ($urandom_range(0, 3) == 0) data_a[15:8] = 8'h00;
            step_a(1);
        end
        rst_a = 1'b0; load_a = 1'b0; en_a = 1'b1;
        step_a(8);

        // CLK_DIV=1 instance: advance every cycle, frame every 4, mid-frame reset.
        rst_b = 1'b1; en_b = 1'b1;
        step_a(2);
        rst_b = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step_a(1);
            check_val("b_an", 32'(an_b), 32'(~(4'b0001 << ((n - 1) % 4)) & 4'hF));
            check_val("b_ft", 32'(ft_b), 32'((n % 4) == 0));
        end
        check_val("b_seg0_prev", 32'(an_b), 32'(4'b1101));
        rst_b = 1'b1;
        step_a(1);
        check_val("b_rst_an", 32'(an_b), 32'hF);
        check_val("b_rst_seg", 32'(seg_b), 32'h7F);
        check_val("b_rst_ft", 32'(ft_b), 32'h0);
        rst_b = 1'b0;
        step_a(1);
        check_val("b_restart_an", 32'(an_b), 32'(4'b1110));
        check_val("b_restart_seg", 32'(seg_b), 32'(7'b0000001));
        step_a(1);
        check_val("b_next_an", 32'(an_b), 32'(4'b1101));

        @(negedge clk);
        #1;
        check_val("sb_drained", 32'(exp_q.size() <= 1), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_7seg_scan.md
Name: display_7seg_scan

Overview:
- Time-multiplexed driver for a bank of common-anode 7-segment digits. It generalises the static per-nibble hex decoder to N digits that share one segment bus.
- Latches a hex word on a load strobe into a shadow register.
- Scans one digit at a time at a programmable refresh rate, driving the shared segment bus and a one-hot-low anode vector.
- Sits between the processor result register (e.g. Fibonacci output) and the board display pins.

Parameters:
- DATA_WIDTH, 16, width of the displayed word. Must be a multiple of 4; NUM_DIGITS = DATA_WIDTH/4 (derived localparam, ≥1).
- CLK_DIV, 100000, clk cycles each digit stays lit. Must be ≥1; prescaler width = $clog2(CLK_DIV) with a minimum of 1.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  DATA_WIDTH  hex word to display; nibble k drives digit k (digit 0 = data_in[3:0]).
- load  in  1  when high at a rising edge, data_in is captured into the shadow register.
- en  in  1  display enable; when low, the display is blanked and the scan freezes.
- seg  out  7  segment bus, active-low, order {a,b,c,d,e,f,g} (seg[6] = a).
- an  out  NUM_DIGITS  anode select, active-low, one-hot; an[k] selects digit k.
- frame_tick  out  1  one-cycle pulse each time the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (rst=1 at an edge):
  - shadow, prescaler and digit index all cleared to 0.
  - an = all 1s, seg = 7'b1111111, frame_tick = 0.
  - rst has priority over load and en.
- Shadow register: shadow <= data_in on any edge where load=1, independent of en and of scan position.
- Prescaler and index (en=1):
  - Prescaler counts 0..CLK_DIV-1.
  - At an edge where the prescaler = CLK_DIV-1: prescaler <= 0 and idx <= idx+1, wrapping NUM_DIGITS-1 -> 0.
  - CLK_DIV=1: idx advances every cycle.
  - NUM_DIGITS=1: idx stays 0, and frame_tick fires on every prescaler wrap.
- en=0: prescaler and idx hold their values. On re-enable the scan resumes at the same digit with the same remaining count.
- Outputs are registered. Each edge:
  - If en: an <= ~(1<<idx) and seg <= hex(shadow nibble idx).
  - Else: an <= all 1s and seg <= 7'b1111111.
- Latencies:
  - Anode/segment change follows an idx change by 1 cycle.
  - New data reaches seg 2 edges after the edge that samples load (shadow update, then output register).
- Hex encoding (active-low, abcdefg):
  - 0: 0000001, 1: 1001111, 2: 0010010, 3: 0000110
  - 4: 1001100, 5: 0100100, 6: 0100000, 7: 0001111
  - 8: 0000000, 9: 0000100, A: 0001000, b: 1100000
  - C: 0110001, d: 1000010, E: 0110000, F: 0111000
- frame_tick is registered. It is 1 in the cycle following the edge where idx wraps NUM_DIGITS-1 -> 0, and 0 otherwise.
- load on the same edge as a digit advance:
  - Both take effect.
  - The scan position is never altered by load.
- Mid-scan rst: scan restarts at digit 0 with the prescaler at 0, and outputs are blank in the cycle following the reset edge.

Optional Feature:
- Macro: DISPLAY_7SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Every digit k above the most significant nonzero nibble of shadow shows seg=7'b1111111. Its anode still asserts in its slot, so timing is unchanged.
  - Digit 0 is never blanked, so shadow=0 shows a single "0".
  - The blank decision is computed from the shadow register, with the same latency as the segment data.
- Undefined: all digits are always decoded, leading zeros included.

Test Plan:
- Reset: hold rst=1 for 3 cycles with load=1 and data_in=16'hFFFF -> an=4'b1111, seg=7'b1111111, frame_tick=0; shadow stays 0, checked after release with en=1: digit 0 seg=0000001.
- Scan (DATA_WIDTH=16, CLK_DIV=4): load 16'h12AF, en=1 -> an sequence 1110/1101/1011/0111, 4 cycles each; seg sequence 0111000/0001000/0010010/1001111; frame_tick is a single pulse every 16 cycles.
- Enable freeze: drop en during digit 2 after 1 of its 4 cycles, for 10 cycles -> an=1111, seg=1111111. After re-enable, digit 2 is lit for the remaining 3 cycles, then digit 3.
- Load mid-scan: load 16'h3333 while digit 1 is lit -> seg=0000110 two edges after the load edge; an and the index sequence are unchanged.
- Boundary (CLK_DIV=1): en=1 -> an advances every cycle; frame_tick pulses every 4 cycles. A rst pulse mid-frame -> blank for one cycle, then digit 0.
- LZB: data 16'h0005:
  - Macro defined -> digits 3..1 show 1111111 with anodes cycling; digit 0 shows 0100100.
  - Macro undefined -> digits 3..1 show 0000001.
  - Data 16'h0000 with macro defined -> digit 0 shows 0000001.
